// File: rtl/control_sequencer_pkg.sv
// Shared constants for the micro-coded control sequencer: opcodes, control-word
// bit positions, single-bit control words and the two fetch words.
package control_sequencer_pkg;

  typedef logic [15:0] ctrl_word_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int BIT_HLT = 15;
  localparam int BIT_MI  = 14;
  localparam int BIT_RI  = 13;
  localparam int BIT_RO  = 12;
  localparam int BIT_IO  = 11;
  localparam int BIT_II  = 10;
  localparam int BIT_AI  = 9;
  localparam int BIT_AO  = 8;
  localparam int BIT_SO  = 7;
  localparam int BIT_SU  = 6;
  localparam int BIT_BI  = 5;
  localparam int BIT_OI  = 4;
  localparam int BIT_CE  = 3;
  localparam int BIT_CO  = 2;
  localparam int BIT_CI  = 1;
  localparam int BIT_FI  = 0;

  localparam ctrl_word_t CW_NONE = 16'h0000;
  localparam ctrl_word_t CW_HLT  = 16'h0001 << BIT_HLT;
  localparam ctrl_word_t CW_MI   = 16'h0001 << BIT_MI;
  localparam ctrl_word_t CW_RI   = 16'h0001 << BIT_RI;
  localparam ctrl_word_t CW_RO   = 16'h0001 << BIT_RO;
  localparam ctrl_word_t CW_IO   = 16'h0001 << BIT_IO;
  localparam ctrl_word_t CW_II   = 16'h0001 << BIT_II;
  localparam ctrl_word_t CW_AI   = 16'h0001 << BIT_AI;
  localparam ctrl_word_t CW_AO   = 16'h0001 << BIT_AO;
  localparam ctrl_word_t CW_SO   = 16'h0001 << BIT_SO;
  localparam ctrl_word_t CW_SU   = 16'h0001 << BIT_SU;
  localparam ctrl_word_t CW_BI   = 16'h0001 << BIT_BI;
  localparam ctrl_word_t CW_OI   = 16'h0001 << BIT_OI;
  localparam ctrl_word_t CW_CE   = 16'h0001 << BIT_CE;
  localparam ctrl_word_t CW_CO   = 16'h0001 << BIT_CO;
  localparam ctrl_word_t CW_CI   = 16'h0001 << BIT_CI;
  localparam ctrl_word_t CW_FI   = 16'h0001 << BIT_FI;

  localparam ctrl_word_t FETCH_T0 = CW_CO | CW_MI;
  localparam ctrl_word_t FETCH_T1 = CW_RO | CW_II | CW_CE;

endpackage

// File: rtl/control_sequencer_step_counter.sv
// Falling-edge micro-step counter with async reset, synchronous clear and a
// sticky halt that freezes the step until reset.
module step_counter #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_halt,
  output logic [W-1:0] o_step,
  output logic         o_halted
);

  logic [W-1:0] r_step;
  logic         r_halted;

  // Step and halt state, updated on the falling edge ahead of datapath loads.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step   <= '0;
      r_halted <= 1'b0;
    end else if (r_halted) begin
      r_step   <= r_step;
      r_halted <= 1'b1;
    end else if (i_halt) begin
      r_step   <= r_step;
      r_halted <= 1'b1;
    end else if (i_clear) begin
      r_step   <= '0;
      r_halted <= 1'b0;
    end else begin
      r_step   <= r_step + W'(1);
      r_halted <= 1'b0;
    end
  end

  assign o_step   = r_step;
  assign o_halted = r_halted;

endmodule

// File: rtl/control_sequencer.sv
// Micro-step decoder producing the 16-bit control word from {opcode, step, CF, ZF}.
// Optional feature macro: CONDITIONAL_JUMP_EN enables JC (7) and JZ (8).
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int STEPS = 5
) (
  input  logic        clk,
  input  logic        RESETn,
  input  logic [3:0]  opcode,
  input  logic        CF,
  input  logic        ZF,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  logic       w_cf;
  logic       w_zf;
  logic [2:0] w_next_step;
  ctrl_word_t w_dec_cur;
  ctrl_word_t w_dec_nxt;
  logic       w_clear;
  logic       w_halt;

`ifdef CONDITIONAL_JUMP_EN
  assign w_cf = CF;
  assign w_zf = ZF;
`else
  // With the flags tied low, JC/JZ never jump and so decode as NOP.
  logic w_unused_flags;
  assign w_unused_flags = CF | ZF;
  assign w_cf = 1'b0;
  assign w_zf = 1'b0;
`endif

  function automatic ctrl_word_t decode(input logic [3:0] op, input logic [2:0] st,
                                        input logic cf, input logic zf);
    ctrl_word_t w;
    w = CW_NONE;
    case (st)
      3'd0: w = FETCH_T0;
      3'd1: w = FETCH_T1;
      default: begin
        case (op)
          OP_LDA: case (st)
            3'd2:    w = CW_IO | CW_MI;
            3'd3:    w = CW_RO | CW_AI;
            default: w = CW_NONE;
          endcase
          OP_ADD, OP_SUB: case (st)
            3'd2:    w = CW_IO | CW_MI;
            3'd3:    w = CW_RO | CW_BI;
            3'd4:    w = CW_SO | CW_AI | CW_FI | ((op == OP_SUB) ? CW_SU : CW_NONE);
            default: w = CW_NONE;
          endcase
          OP_STA: case (st)
            3'd2:    w = CW_IO | CW_MI;
            3'd3:    w = CW_AO | CW_RI;
            default: w = CW_NONE;
          endcase
          OP_LDI:  w = (st == 3'd2) ? (CW_IO | CW_AI) : CW_NONE;
          OP_JMP:  w = (st == 3'd2) ? (CW_IO | CW_CI) : CW_NONE;
          OP_JC:   w = (st == 3'd2 && cf) ? (CW_IO | CW_CI) : CW_NONE;
          OP_JZ:   w = (st == 3'd2 && zf) ? (CW_IO | CW_CI) : CW_NONE;
          OP_OUT:  w = (st == 3'd2) ? (CW_AO | CW_OI) : CW_NONE;
          OP_HLT:  w = (st == 3'd2) ? CW_HLT : CW_NONE;
          default: w = CW_NONE;
        endcase
      end
    endcase
    return w;
  endfunction

  assign w_next_step = step + 3'd1;
  assign w_dec_cur   = decode(opcode, step, w_cf, w_zf);
  assign w_dec_nxt   = decode(opcode, w_next_step, w_cf, w_zf);
  assign w_halt      = w_dec_cur[BIT_HLT];

  // Next-step selection; an empty following step is skipped so no dead cycle is spent.
  always_comb begin
    w_clear = 1'b0;
    if (step == 3'(STEPS - 1)) begin
      w_clear = 1'b1;
    end else if (step >= 3'd2) begin
      w_clear = (w_dec_cur == CW_NONE) || (w_dec_nxt == CW_NONE);
    end else begin
      w_clear = 1'b0;
    end
  end

  // Control word output; a halted sequencer only ever shows HLT.
  always_comb begin
    ctrl = CW_NONE;
    if (halted) begin
      ctrl = CW_HLT;
    end else begin
      ctrl = w_dec_cur;
    end
  end

  step_counter #(.W(3)) u_step_counter (
    .i_clk    (clk),
    .i_rst_n  (RESETn),
    .i_clear  (w_clear),
    .i_halt   (w_halt),
    .o_step   (step),
    .o_halted (halted)
  );

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter STEPS, default 5, number of micro-steps per instruction (T0..T4); allowed range 3..8.
REQ-002 Port clk  input  1  system clock.
REQ-003 Port RESETn  input  1  reset, asynchronous and active-low.
REQ-004 Port opcode  input  4  instruction register upper nibble.
REQ-005 Port CF  input  1  carry flag from the flags register.
REQ-006 Port ZF  input  1  zero flag from the flags register.
REQ-007 Port ctrl  output  16  control word, bit map: HLT15 MI14 RI13 RO12 IO11 II10 AI9 AO8 SO7 SU6 BI5 OI4 CE3 CO2 CI1 FI0.
REQ-008 Port step  output  3  current micro-step index.
REQ-009 Port halted  output  1  sequencer frozen by HLT.

Function
REQ-010 The step counter SHALL advance on the falling edge of clk, so that ctrl is stable before the rising edge at which the datapath registers load.
REQ-011 ctrl SHALL be a combinational decode of {opcode, step, CF, ZF} with no added latency.
REQ-012 Fetch: T0 = CO|MI; T1 = RO|II|CE, for every opcode.
REQ-013 Execute steps:
- LDA(1): T2 IO|MI; T3 RO|AI.
- ADD(2): T2 IO|MI; T3 RO|BI; T4 SO|AI|FI.
- SUB(3): same as ADD plus SU at T4.
- STA(4): T2 IO|MI; T3 AO|RI.
- LDI(5): T2 IO|AI.
- JMP(6): T2 IO|CI.
- OUT(E): T2 AO|OI.
- HLT(F): T2 HLT.
REQ-014 Undefined opcodes (0, 9..D) SHALL decode as NOP: all-zero ctrl from T2 onward.
REQ-015 Early end: when step ≥ 2 and the decoded ctrl is all-zero, the next falling edge SHALL load step 0 instead of step+1.
REQ-016 Wrap: after step STEPS-1 the next falling edge SHALL load step 0.
REQ-017 CO and CI SHALL never be asserted in the same step. CE and CI SHALL never be asserted in the same step.
REQ-018 HLT: at the falling edge in which ctrl[15]=1, halted SHALL go 1 and step SHALL freeze. ctrl SHALL be forced to 16'h8000 until reset.
REQ-019 Flags are sampled combinationally in the same step they are used. There is no internal flag storage.

Reset
REQ-020 Asserting RESETn low SHALL immediately set step=0 and halted=0, which forces ctrl=CO|MI (16'h4004).
REQ-021 Reset asserted mid-instruction SHALL abandon that instruction. No partial-step output SHALL persist after reset.
REQ-022 Release of RESETn SHALL take effect at the next falling edge; the first fetch begins from step 0.

Configuration
REQ-023 Macro CONDITIONAL_JUMP_EN:
- When defined: JC(7): T2 IO|CI if CF=1, else all-zero (early end). JZ(8): T2 IO|CI if ZF=1, else all-zero.
- When undefined: opcodes 7 and 8 decode as NOP, and CF/ZF are unused.

Structure
REQ-024 A shared package SHALL hold:
- opcode constants;
- ctrl bit-position constants;
- the fetch-word constants.
REQ-025 A sub-module step_counter SHALL implement the falling-edge counter with async reset, sync clear (early end/wrap) and hold (halt). The decode SHALL stay in control_sequencer.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Reset low, then opcode=1 released -> step sequence 0,1,2,3,0; ctrl 4004, 1408, 4800, 1200, 4004.
- opcode=3 (SUB) -> step 4 ctrl=SO|SU|AI|FI = 16'h02C1; next step 0.
- opcode=5 (LDI) -> T3 ctrl=0 never appears; step goes 2 -> 0 (early end).
- opcode=F -> halted=1 after the T2 falling edge; ctrl holds 16'h8000 for 10 cycles; RESETn pulse -> step=0, ctrl=16'h4004.
- With CONDITIONAL_JUMP_EN: opcode=7 with CF=1 -> T2 ctrl=16'h0802; with CF=0 -> step 2 -> 0. Without the macro -> NOP both cases.
- RESETn asserted at step 3 of ADD between clock edges -> step=0 and ctrl=16'h4004 without waiting for a clock edge.
